// File: rtl/conv_pool_pixel_seq.sv
// Channel-serial XNOR-popcount convolution over P*P pool positions, accumulated
// across CHAN beats, thresholded against an offset and pooled to one output bit.
module conv_pool_pixel_seq #(
  parameter int K    = 5,
  parameter int P    = 2,
  parameter int CHAN = 5,
  parameter int BW   = $clog2(CHAN*K*K+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [(K+P-1)*(K+P-1)-1:0]     in_image,
  input  logic [K*K-1:0]                 in_kernel,
  input  logic [BW-1:0]                  in_offset,
  input  logic                           in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_pixel,
  output logic [P*P*BW-1:0]              out_sums
);

  localparam int WIN = K + P - 1;
  localparam int NP  = P * P;
  localparam int CW  = $clog2(CHAN + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   ch_cnt_reg, ch_cnt_next;
  logic [BW-1:0]   acc_reg  [NP];
  logic [BW-1:0]   acc_next [NP];
  logic [BW-1:0]   offset_reg;
  logic            mode_reg;
  logic            pixel_reg;

  logic            accept;
  logic            first_beat;
  logic [BW-1:0]   offset_eff;
  logic            mode_eff;
  logic [NP-1:0]   bin;
  logic            pixel_next;

  // rst gates in_ready so nothing is accepted while the block is held in reset
  assign in_ready   = !rst && (state_reg != DONE);
  assign accept     = in_valid && in_ready;
  assign first_beat = (state_reg == IDLE);

  // The first beat of a pixel supplies offset/mode directly (needed when CHAN==1)
  assign offset_eff = first_beat ? in_offset : offset_reg;
  assign mode_eff   = first_beat ? in_mode   : mode_reg;

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_pos
      localparam int PY = gi / P;
      localparam int PX = gi % P;

      logic [K*K-1:0] match;
      logic [BW-1:0]  pc;

      always_comb begin
        match = '0;
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) begin
            match[ky*K+kx] = ~(in_image[(PY+ky)*WIN+PX+kx] ^ in_kernel[ky*K+kx]);
          end
        end
      end

      always_comb begin
        pc = '0;
        for (int j = 0; j < K*K; j++) begin
          pc = pc + BW'(match[j]);
        end
      end

      assign acc_next[gi]            = first_beat ? pc : acc_reg[gi] + pc;
      assign bin[gi]                 = (acc_next[gi] > offset_eff);
      assign out_sums[gi*BW +: BW]   = acc_reg[gi];
    end
  endgenerate

  assign pixel_next = mode_eff ? (&bin) : (|bin);

  always_comb begin
    state_next  = state_reg;
    ch_cnt_next = ch_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          if (CHAN == 1) begin
            state_next  = DONE;
            ch_cnt_next = '0;
          end else begin
            state_next  = ACCUM;
            ch_cnt_next = CW'(1);
          end
        end
      end
      ACCUM: begin
        if (accept) begin
          if (ch_cnt_reg == CW'(CHAN - 1)) begin
            state_next  = DONE;
            ch_cnt_next = '0;
          end else begin
            ch_cnt_next = ch_cnt_reg + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      ch_cnt_reg <= '0;
      offset_reg <= '0;
      mode_reg   <= 1'b0;
      pixel_reg  <= 1'b0;
      for (int i = 0; i < NP; i++) acc_reg[i] <= '0;
    end else begin
      state_reg  <= state_next;
      ch_cnt_reg <= ch_cnt_next;
      if (accept) begin
        acc_reg <= acc_next;
        if (first_beat) begin
          offset_reg <= in_offset;
          mode_reg   <= in_mode;
        end
        if (state_next == DONE) pixel_reg <= pixel_next;
      end
    end
  end

  assign out_valid = (state_reg == DONE);
  assign out_pixel = pixel_reg;

endmodule

// File: tb/tb_conv_pool_pixel_seq.sv
// Directed bench: default instance (K=5,P=2,CHAN=5) plus a K=3,P=3,CHAN=1 instance.
module tb_conv_pool_pixel_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default instance
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [35:0] in_image = '0;
  logic [24:0] in_kernel = '0;
  logic [6:0]  in_offset = '0;
  logic        in_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_pixel;
  logic [27:0] out_sums;

  // sweep instance
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [24:0] s_in_image = '0;
  logic [8:0]  s_in_kernel = '0;
  logic [3:0]  s_in_offset = '0;
  logic        s_in_mode = 1'b0;
  logic        s_out_valid;
  logic        s_out_ready = 1'b0;
  logic        s_out_pixel;
  logic [35:0] s_out_sums;

  int errors = 0;
  int checks = 0;

  logic [35:0] img_ones;
  logic [35:0] img_col;
  logic [24:0] ker_ones;
  logic [27:0] sums_125;
  logic [27:0] sums_col;

  conv_pool_pixel_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_image(in_image), .in_kernel(in_kernel),
    .in_offset(in_offset), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sums(out_sums)
  );

  conv_pool_pixel_seq #(.K(3), .P(3), .CHAN(1)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_image(s_in_image), .in_kernel(s_in_kernel),
    .in_offset(s_in_offset), .in_mode(s_in_mode),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pixel(s_out_pixel), .out_sums(s_out_sums)
  );

  // Presents one beat at a negedge and returns at the negedge after it was taken.
  task automatic send_beat(input logic [35:0] img, input logic [24:0] ker,
                           input logic [6:0] off, input logic mode);
    int n;
    in_image  = img;
    in_kernel = ker;
    in_offset = off;
    in_mode   = mode;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout in_ready got=%b required=1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic int ref_sum(logic [24:0] img, logic [8:0] ker, int py, int px);
    int s = 0;
    for (int ky = 0; ky < 3; ky++)
      for (int kx = 0; kx < 3; kx++)
        if (img[(py+ky)*5+px+kx] == ker[ky*3+kx]) s++;
    return s;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    checks++; if (out_pixel !== 1'b0) begin errors++; $display("FAIL rst_out_pixel got=%b required=0", out_pixel); end
    checks++; if (out_sums !== 28'd0) begin errors++; $display("FAIL rst_out_sums got=%h required=0", out_sums); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_s_out_valid got=%b required=0", s_out_valid); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b required=1", in_ready); end
    @(negedge clk);
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_all_ones();
    logic [6:0] offs [2] = '{7'd124, 7'd125};
    logic       exp_pix [2] = '{1'b1, 1'b0};
    for (int t = 0; t < 2; t++) begin
      for (int b = 0; b < 5; b++) begin
        send_beat(img_ones, ker_ones, offs[t], 1'b0);
        if (b == 3) begin
          checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got=%b required=0", out_valid); end
        end
      end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ones_latency out_valid got=%b required=1", out_valid); end
      checks++; if (out_sums !== sums_125) begin errors++; $display("FAIL ones_sums got=%h required=%h", out_sums, sums_125); end
      checks++; if (out_pixel !== exp_pix[t]) begin errors++; $display("FAIL ones_pixel off=%0d got=%b required=%b", offs[t], out_pixel, exp_pix[t]); end
      $display("all_ones off=%0d sums=%h pixel=%b", offs[t], out_sums, out_pixel);
      handshake();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ones_release out_valid got=%b required=0", out_valid); end
    end
  endtask

  task automatic test_column();
    logic exp_pix [2] = '{1'b0, 1'b1};
    for (int t = 0; t < 2; t++) begin
      logic mode;
      mode = (t == 0);
      for (int b = 0; b < 5; b++) send_beat(img_col, ker_ones, 7'd120, mode);
      checks++; if (out_sums !== sums_col) begin errors++; $display("FAIL col_sums mode=%b got=%h required=%h", mode, out_sums, sums_col); end
      checks++; if (out_pixel !== exp_pix[t]) begin errors++; $display("FAIL col_pixel mode=%b got=%b required=%b", mode, out_pixel, exp_pix[t]); end
      $display("column mode=%b sums=%h pixel=%b", mode, out_sums, out_pixel);
      handshake();
    end
  endtask

  task automatic test_backpressure();
    for (int b = 0; b < 5; b++) send_beat(img_ones, ker_ones, 7'd124, 1'b0);
    in_image  = img_col;
    in_kernel = ker_ones;
    in_offset = 7'd120;
    in_mode   = 1'b1;
    in_valid  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b required=0", c, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_pixel !== 1'b1 || out_sums !== sums_125) begin
        errors++; $display("FAIL bp_hold cyc=%0d got valid=%b pixel=%b sums=%h required 1/1/%h", c, out_valid, out_pixel, out_sums, sums_125);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_handshake_in_ready got=%b required=0", in_ready); end
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_after_hs got valid=%b ready=%b required 0/1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      send_beat(img_col, ker_ones, 7'd0, 1'b0);
      if (b == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_early_valid got=%b required=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_next_valid got=%b required=1", out_valid); end
    checks++; if (out_sums !== sums_col) begin errors++; $display("FAIL bp_next_sums got=%h required=%h", out_sums, sums_col); end
    checks++; if (out_pixel !== 1'b0) begin errors++; $display("FAIL bp_next_pixel got=%b required=0", out_pixel); end
    $display("backpressure next sums=%h pixel=%b", out_sums, out_pixel);
    handshake();
  endtask

  task automatic test_stalls();
    for (int b = 0; b < 5; b++) begin
      send_beat(img_ones, ker_ones, (b == 2) ? 7'd125 : 7'd124, (b == 2));
      if (b < 4) begin
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid beat=%0d got=%b required=0", b, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_done got=%b required=1", out_valid); end
    checks++; if (out_sums !== sums_125) begin errors++; $display("FAIL stall_sums got=%h required=%h", out_sums, sums_125); end
    checks++; if (out_pixel !== 1'b1) begin errors++; $display("FAIL stall_pixel got=%b required=1", out_pixel); end
    $display("stalls sums=%h pixel=%b", out_sums, out_pixel);
    handshake();
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 3; b++) send_beat(36'd0, ker_ones, 7'd0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sums !== 28'd0) begin
      errors++; $display("FAIL midrst_state got ready=%b valid=%b sums=%h required 0/0/0", in_ready, out_valid, out_sums);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output cyc=%0d got=%b required=0", c, out_valid); end
    end
    for (int b = 0; b < 5; b++) begin
      send_beat(img_ones, ker_ones, 7'd124, 1'b0);
      if (b == 3) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_early_valid got=%b required=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_valid got=%b required=1", out_valid); end
    checks++; if (out_sums !== sums_125) begin errors++; $display("FAIL midrst_sums got=%h required=%h", out_sums, sums_125); end
    checks++; if (out_pixel !== 1'b1) begin errors++; $display("FAIL midrst_pixel got=%b required=1", out_pixel); end
    $display("reset_mid fresh sums=%h pixel=%b", out_sums, out_pixel);
    handshake();
  endtask

  task automatic test_sweep();
    logic [24:0] v_img [6] = '{25'h1A53C7E, 25'h1A53C7E, 25'h0B6D2F1, 25'h0000000, 25'h1FFFFFF, 25'h1FFFFFF};
    logic [8:0]  v_ker [6] = '{9'h0B5,    9'h0B5,    9'h16C,    9'h1FF,    9'h1FF,    9'h1FF};
    logic [3:0]  v_off [6] = '{4'd4,      4'd4,      4'd5,      4'd0,      4'd9,      4'd8};
    logic        v_mode[6] = '{1'b0,      1'b1,      1'b1,      1'b0,      1'b0,      1'b1};
    for (int t = 0; t < 6; t++) begin
      int  s;
      logic any_b, all_b, exp_pix;
      s_in_image  = v_img[t];
      s_in_kernel = v_ker[t];
      s_in_offset = v_off[t];
      s_in_mode   = v_mode[t];
      s_in_valid  = 1'b1;
      checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL sweep_ready vec=%0d got=%b required=1", t, s_in_ready); end
      @(negedge clk);
      s_in_valid = 1'b0;
      checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid vec=%0d got=%b required=1", t, s_out_valid); end
      any_b = 1'b0;
      all_b = 1'b1;
      for (int i = 0; i < 9; i++) begin
        s = ref_sum(v_img[t], v_ker[t], i / 3, i % 3);
        checks++; if (s_out_sums[i*4 +: 4] !== 4'(s)) begin
          errors++; $display("FAIL sweep_sum vec=%0d pos=%0d got=%0d required=%0d", t, i, s_out_sums[i*4 +: 4], s);
        end
        if (s > int'(v_off[t])) any_b = 1'b1; else all_b = 1'b0;
      end
      exp_pix = v_mode[t] ? all_b : any_b;
      checks++; if (s_out_pixel !== exp_pix) begin errors++; $display("FAIL sweep_pixel vec=%0d got=%b required=%b", t, s_out_pixel, exp_pix); end
      $display("sweep vec=%0d mode=%b off=%0d sums=%h pixel=%b", t, v_mode[t], v_off[t], s_out_sums, s_out_pixel);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    img_ones = '1;
    img_col  = '1;
    for (int r = 0; r < 6; r++) img_col[r*6+5] = 1'b0;
    ker_ones = '1;
    sums_125 = {7'd125, 7'd125, 7'd125, 7'd125};
    sums_col = {7'd100, 7'd125, 7'd100, 7'd125};

    test_reset();
    test_all_ones();
    test_column();
    test_backpressure();
    test_stalls();
    test_reset_mid();
    test_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_pool_pixel_seq.md
Name: conv_pool_pixel_seq

Overview:
Channel-serial binary convolution plus pooling engine that produces one pooled output pixel.
- Each beat carries one input channel: a WIN x WIN binary image patch and a K x K binary kernel. WIN = K+P-1.
- For each of the P*P pooling positions, the block accumulates XNOR-popcounts over CHAN beats.
- Each of the P*P sums is thresholded against an offset, then the P*P results are pooled to one bit.
- Successor to the fixed 5-channel, 5x5, 2x2-pool combinational pixel. It adds generic K/P/CHAN, per-channel image planes, valid/ready flow control and a selectable pool mode. It sits between the patch/kernel fetch logic and the layer output buffer.

Parameters:
K, 5, kernel side length (>=1)
P, 2, pool side length (>=1); pool positions NP = P*P
CHAN, 5, channel beats per pixel (>=1)
BW, $clog2(CHAN*K*K+1), accumulator/offset width (7 at defaults)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  channel beat valid
in_ready  output  1  block accepts beat when high
in_image  input  (K+P-1)*(K+P-1)  patch; bit r*WIN+c = row r, col c
in_kernel  input  K*K  kernel; bit ky*K+kx
in_offset  input  BW  threshold; sampled on first beat only
in_mode  input  1  pool mode, sampled on first beat: 0 = OR (max), 1 = AND (min)
out_valid  output  1  pooled pixel valid
out_ready  input  1  downstream accepts pixel
out_pixel  output  1  pooled binary pixel
out_sums  output  NP*BW  final per-position sums; position (py,px) at slice index py*P+px

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst; every register is cleared on the clk edge where rst=1.
- Reset values:
  - in_ready=0 during reset; becomes 1 in the first cycle after rst deasserts.
  - out_valid=0, out_pixel=0, out_sums=0.
  - ch_cnt=0, state=IDLE.
- State machine:
  - IDLE: in_ready=1. An accepted beat (in_valid&in_ready) loads the accumulators with this beat's popcounts (no add) and latches offset and mode. It moves to ACCUM, or straight to DONE if CHAN==1. ch_cnt is set to 1.
  - ACCUM: in_ready=1. Each accepted beat adds its popcounts to acc[i] and increments ch_cnt. The beat accepted with ch_cnt==CHAN-1 moves the FSM to DONE and clears ch_cnt.
  - DONE: in_ready=0, out_valid=1, outputs stable. When out_valid&out_ready, the FSM returns to IDLE. The next beat is accepted no earlier than the following cycle.
- Per-beat arithmetic for position (py,px):
  - pc = sum over ky,kx of ~(in_image[(py+ky)*WIN+px+kx] ^ in_kernel[ky*K+kx]).
  - Range 0..K*K. Unsigned, zero-extended to BW.
  - Accumulation cannot overflow: max CHAN*K*K fits BW by construction.
- Output computation:
  - bin[i] = (acc[i] > offset), strict unsigned compare.
  - out_pixel = OR of bin[] (mode 0) or AND of bin[] (mode 1).
  - out_pixel is registered on entry to DONE.
  - out_sums = acc[] as frozen on the final beat.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: best case CHAN+1 cycles per pixel when out_ready is held high.
- Gaps: in_valid low mid-pixel stalls accumulation, with no state loss and no timeout.
- Offset/mode changes on non-first beats are ignored.
- Backpressure: while out_ready=0 in DONE, the outputs hold and no beats are accepted.
- rst asserted mid-ACCUM or in DONE: the partial pixel is discarded, outputs return to reset values next cycle, and no output is ever produced for the aborted pixel.
- Edge cases:
  - offset >= CHAN*K*K gives bin=0 for all positions.
  - offset = 0 gives bin=1 unless that position's sum is 0.
- No combinational path from in_valid to in_ready, or from out_ready to any output other than via the FSM register.

Test Plan:
1. Defaults; 5 beats with image and kernel all ones, offset=124, mode=0 -> out_valid in the cycle after beat 5; all out_sums=125; out_pixel=1. Repeat with offset=125 -> out_pixel=0.
2. Defaults; kernel all ones; image column 5 all zeros; offset=120; mode=1 -> sums for positions 0,2 = 125 and positions 1,3 = 100; out_pixel=0 (AND). Same with mode=0 -> out_pixel=1.
3. Backpressure: hold out_ready=0 for 4 cycles after out_valid; drive in_valid=1 throughout -> in_ready=0, out_pixel/out_sums stable. The next pixel's first beat is accepted only after the handshake cycle.
4. Stalls: in_valid toggling 1,0,0,1,... across 5 beats; change in_offset on beat 3 -> result identical to the unstalled run with the beat-1 offset.
5. Reset mid-pixel: rst for 1 cycle after beat 3 -> out_valid stays 0. The next 5 beats yield a correct fresh pixel, not contaminated by the 3 discarded beats.
6. Parameter sweep K=3, P=3, CHAN=1 (BW=4): a single beat with random image/kernel -> out_valid next cycle; out_sums matches the reference model for all 9 positions; out_pixel correct for both modes.
